// File: rtl/turn_signal_ctrl.sv
// Turn-indicator controller: left/right steady blink, hazard toggle and a
// short-tap "comfort" lane-change blink. Lamp outputs and the blink-phase
// level for the downstream sound unit are registered.
module turn_signal_ctrl #(
  parameter int HALF_PERIOD_CYC = 16_666_667,
  parameter int TAP_CYC         = 20_000_000,
  parameter int COMFORT_FLASHES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       engine_on,
  input  logic       stalk_left,
  input  logic       stalk_right,
  input  logic       hazard_btn,
  output logic       lamp_left,
  output logic       lamp_right,
  output logic       turn_signal_on,
  output logic [2:0] mode
);

  localparam int BW = (HALF_PERIOD_CYC > 1) ? $clog2(HALF_PERIOD_CYC) : 1;
  localparam int TW = $clog2(TAP_CYC + 1);
  localparam int FW = $clog2(COMFORT_FLASHES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_PERIOD_CYC - 1);
  localparam logic [TW-1:0] TAP_MAX    = TW'(TAP_CYC);
  localparam logic [FW-1:0] FLASH_MAX  = FW'(COMFORT_FLASHES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    COMF_L = 3'd3,
    COMF_R = 3'd4,
    HAZARD = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [2:0]    sync1, sync2, prev;
  logic [BW-1:0] blink_cnt, blink_next;
  logic [TW-1:0] tap_cnt, tap_next;
  logic [FW-1:0] flash_cnt, flash_next, flash_base;
  logic          phase, phase_next;
  logic          hazard, hazard_next;
  logic          valid_l, valid_r, left_edge, right_edge, hz_rise;
  logic          blink_tc, phase_rise, comf_done, entering, reentry;

  // Two-flop synchronizer for the asynchronous pins plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {hazard_btn, stalk_right, stalk_left};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign valid_l    = sync2[0] & ~sync2[1] & engine_on;
  assign valid_r    = sync2[1] & ~sync2[0] & engine_on;
  assign left_edge  = valid_l & ~prev[0];
  assign right_edge = valid_r & ~prev[1];
  assign hz_rise    = sync2[2] & ~prev[2];
  assign blink_tc   = (blink_cnt == BLINK_LAST);
  assign comf_done  = (flash_cnt >= FLASH_MAX) && (!phase || blink_tc);

  // Next-state selection; a set hazard latch overrides every other decision
  always_comb begin
    hazard_next = hazard ^ hz_rise;
    state_next  = state;
    case (state)
      IDLE: begin
        if (left_edge)       state_next = LEFT;
        else if (right_edge) state_next = RIGHT;
      end
      LEFT: begin
        if (!engine_on)      state_next = IDLE;
        else if (!valid_l)   state_next = (tap_cnt < TAP_MAX) ? COMF_L : IDLE;
      end
      RIGHT: begin
        if (!engine_on)      state_next = IDLE;
        else if (!valid_r)   state_next = (tap_cnt < TAP_MAX) ? COMF_R : IDLE;
      end
      COMF_L: begin
        if (!engine_on)      state_next = IDLE;
        else if (right_edge) state_next = RIGHT;
        else if (left_edge)  state_next = LEFT;
        else if (comf_done)  state_next = IDLE;
      end
      COMF_R: begin
        if (!engine_on)      state_next = IDLE;
        else if (left_edge)  state_next = LEFT;
        else if (right_edge) state_next = RIGHT;
        else if (comf_done)  state_next = IDLE;
      end
      HAZARD: begin
        if (valid_l)         state_next = LEFT;
        else if (valid_r)    state_next = RIGHT;
        else                 state_next = IDLE;
      end
      default:               state_next = IDLE;
    endcase
    if (hazard_next) state_next = HAZARD;
  end

  // Blink timer, tap timer and flash counter updates; active-to-active moves keep the phase running
  always_comb begin
    entering   = (state == IDLE) && (state_next != IDLE);
    reentry    = ((state == COMF_L) || (state == COMF_R)) &&
                 ((state_next == LEFT) || (state_next == RIGHT));
    phase_rise = blink_tc & ~phase;
    flash_base = reentry ? '0 : flash_cnt;
    blink_next = blink_tc ? '0 : blink_cnt + BW'(1);
    phase_next = blink_tc ? ~phase : phase;
    tap_next   = reentry ? '0 : ((tap_cnt == TAP_MAX) ? tap_cnt : tap_cnt + TW'(1));
    flash_next = (phase_rise && (flash_base != FLASH_MAX)) ? flash_base + FW'(1) : flash_base;
    if (state_next == IDLE) begin
      blink_next = '0;
      phase_next = 1'b0;
      tap_next   = '0;
      flash_next = '0;
    end else if (entering) begin
      blink_next = '0;
      phase_next = 1'b1;
      tap_next   = '0;
      flash_next = FW'(1);
    end
  end

  // State, timers and registered lamp outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      hazard         <= 1'b0;
      blink_cnt      <= '0;
      phase          <= 1'b0;
      tap_cnt        <= '0;
      flash_cnt      <= '0;
      lamp_left      <= 1'b0;
      lamp_right     <= 1'b0;
      turn_signal_on <= 1'b0;
    end else begin
      state          <= state_next;
      hazard         <= hazard_next;
      blink_cnt      <= blink_next;
      phase          <= phase_next;
      tap_cnt        <= tap_next;
      flash_cnt      <= flash_next;
      lamp_left      <= phase_next & ((state_next == LEFT) || (state_next == COMF_L) ||
                                      (state_next == HAZARD));
      lamp_right     <= phase_next & ((state_next == RIGHT) || (state_next == COMF_R) ||
                                      (state_next == HAZARD));
      turn_signal_on <= phase_next & (state_next != IDLE);
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with short timing parameters.
module tb_turn_signal_ctrl;

  logic       clk = 1'b0;
  logic       rst, engine_on, stalk_left, stalk_right, hazard_btn;
  logic       lamp_left, lamp_right, turn_signal_on;
  logic [2:0] mode;
  int         total = 0;
  int         bad   = 0;

  turn_signal_ctrl #(
    .HALF_PERIOD_CYC(10),
    .TAP_CYC(25),
    .COMFORT_FLASHES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .engine_on(engine_on),
    .stalk_left(stalk_left),
    .stalk_right(stalk_right),
    .hazard_btn(hazard_btn),
    .lamp_left(lamp_left),
    .lamp_right(lamp_right),
    .turn_signal_on(turn_signal_on),
    .mode(mode)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic sl, input logic sr, input logic hz, input logic eng);
    stalk_left  = sl;
    stalk_right = sr;
    hazard_btn  = hz;
    engine_on   = eng;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] m, input logic ll,
                          input logic lr, input logic ts);
    checkOutput({tag, ".mode"}, mode, m);
    checkOutput({tag, ".lamp_left"}, {2'b00, lamp_left}, {2'b00, ll});
    checkOutput({tag, ".lamp_right"}, {2'b00, lamp_right}, {2'b00, lr});
    checkOutput({tag, ".turn_on"}, {2'b00, turn_signal_on}, {2'b00, ts});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1);
    tick(3);
    rst = 1'b0;
    checkAll("reset", 3'd0, 0, 0, 0);
    tick(1);

    // Held left stalk: 3-edge latency, 10 on / 10 off, then release to idle
    applyStimulus(1, 0, 0, 1);
    tick(2);  checkAll("left_latency", 3'd0, 0, 0, 0);
    tick(1);  checkAll("left_on", 3'd1, 1, 0, 1);
    tick(9);  checkAll("left_on_end", 3'd1, 1, 0, 1);
    tick(1);  checkAll("left_off", 3'd1, 0, 0, 0);
    tick(10); checkAll("left_on2", 3'd1, 1, 0, 1);
    tick(77); applyStimulus(0, 0, 0, 1);
    tick(2);  checkOutput("left_rel_wait.mode", mode, 3'd1);
    tick(1);  checkAll("left_release", 3'd0, 0, 0, 0);
    tick(2);

    // Short right tap: comfort blink of exactly three ON phases
    applyStimulus(0, 1, 0, 1);
    tick(3);  checkAll("tap_on", 3'd2, 0, 1, 1);
    tick(2);  applyStimulus(0, 0, 0, 1);
    tick(3);  checkAll("comf_r", 3'd4, 0, 1, 1);
    tick(5);  checkAll("comf_off1", 3'd4, 0, 0, 0);
    tick(10); checkAll("comf_on2", 3'd4, 0, 1, 1);
    tick(9);  checkAll("comf_on2_end", 3'd4, 0, 1, 1);
    tick(1);  checkAll("comf_off2", 3'd4, 0, 0, 0);
    tick(19); checkAll("comf_on3_end", 3'd4, 0, 1, 1);
    tick(1);  checkAll("comf_done", 3'd0, 0, 0, 0);
    tick(2);

    // Held left, hazard on then off with a continuous phase
    applyStimulus(1, 0, 0, 1);
    tick(3);  checkAll("hz_left_on", 3'd1, 1, 0, 1);
    tick(37); applyStimulus(1, 0, 1, 1);
    tick(2);  checkAll("hz_pre", 3'd1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    tick(1);  checkAll("hz_enter", 3'd5, 1, 1, 1);
    tick(9);  checkAll("hz_on_end", 3'd5, 1, 1, 1);
    tick(1);  checkAll("hz_off", 3'd5, 0, 0, 0);
    tick(7);  applyStimulus(1, 0, 1, 1);
    tick(2);  applyStimulus(1, 0, 0, 1);
    tick(1);  checkAll("hz_exit_left", 3'd1, 1, 0, 1);
    tick(10); checkAll("hz_left_off", 3'd1, 0, 0, 0);
    tick(7);  applyStimulus(0, 0, 0, 1);
    tick(3);  checkAll("hz_left_rel", 3'd0, 0, 0, 0);
    tick(2);

    // Engine off: hazard still works, stalk ignored, second press goes idle
    applyStimulus(0, 0, 1, 0);
    tick(2);  applyStimulus(0, 0, 0, 0);
    tick(1);  checkAll("eng_off_hz", 3'd5, 1, 1, 1);
    tick(2);  applyStimulus(1, 0, 0, 0);
    tick(5);  checkAll("eng_off_stalk", 3'd5, 1, 1, 1);
    tick(2);  applyStimulus(1, 0, 1, 0);
    tick(2);  applyStimulus(1, 0, 0, 0);
    tick(1);  checkAll("eng_off_hz_clear", 3'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    tick(3);  checkAll("eng_on_idle", 3'd0, 0, 0, 0);

    // Comfort-left cancelled by right stalk during an ON phase
    applyStimulus(1, 0, 0, 1);
    tick(5);  applyStimulus(0, 0, 0, 1);
    tick(3);  checkAll("cl_comf", 3'd3, 1, 0, 1);
    tick(14); applyStimulus(0, 1, 0, 1);
    tick(2);  checkAll("cl_before", 3'd3, 1, 0, 1);
    tick(1);  checkAll("cl_switch", 3'd2, 0, 1, 1);
    tick(7);  checkAll("cl_on_end", 3'd2, 0, 1, 1);
    tick(1);  checkAll("cl_off", 3'd2, 0, 0, 0);
    tick(7);  applyStimulus(0, 0, 0, 1);
    tick(3);  checkAll("cl_comf_r", 3'd4, 0, 1, 1);
    tick(49); checkAll("cl_comf_r_last", 3'd4, 0, 1, 1);
    tick(1);  checkAll("cl_comf_r_done", 3'd0, 0, 0, 0);
    tick(2);

    // Reset in the middle of a hazard ON phase loses the hazard latch
    applyStimulus(0, 0, 1, 1);
    tick(2);  applyStimulus(0, 0, 0, 1);
    tick(1);  checkAll("rst_hz_on", 3'd5, 1, 1, 1);
    tick(2);  rst = 1'b1;
    tick(1);  checkAll("rst_cleared", 3'd0, 0, 0, 0);
    rst = 1'b0;
    tick(5);  checkAll("rst_stays_idle", 3'd0, 0, 0, 0);
    tick(1);  applyStimulus(0, 0, 1, 1);
    tick(2);  applyStimulus(0, 0, 0, 1);
    tick(1);  checkAll("rst_hz_again", 3'd5, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
